// File: rtl/beam_fp_pkg.sv
// Shared types and constants for the beamforming FP sequencer.
// It holds the FSM state encoding, the default core opcodes and the float constant 1.0.
package beam_fp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CVT_ISSUE,
    CVT_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    ADD_ISSUE,
    ADD_WAIT,
    FIX_ISSUE,
    FIX_WAIT,
    DONE
  } state_t;

  localparam logic [2:0] OP_FLOATIS_DEF = 3'd0;
  localparam logic [2:0] OP_FMUL_DEF    = 3'd1;
  localparam logic [2:0] OP_FADD_DEF    = 3'd2;
  localparam logic [2:0] OP_FIXSI_DEF   = 3'd3;

  localparam logic [31:0] FP_ONE = 32'h3F800000;

endpackage

// File: rtl/beam_coef_regs.sv
// Per-channel IEEE-754 weight register file.
// Every weight resets to 1.0. The read port is combinational.
module beam_coef_regs
  import beam_fp_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int AW   = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_w [N_CH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_CH; i++) r_w[i] <= FP_ONE;
    end else if (i_we && (int'(i_waddr) < N_CH)) begin
      r_w[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (int'(i_raddr) < N_CH) ? r_w[i_raddr] : FP_ONE;

endmodule

// File: rtl/beam_fp_sequencer.sv
// Drives the shared FP core to form one weighted channel sum per audio frame.
// Per channel the op chain is int->float, multiply by weight, accumulate; float->int runs last.
module beam_fp_sequencer
  import beam_fp_pkg::*;
#(
  parameter int         N_CH       = 4,
  parameter logic [2:0] OP_FLOATIS = OP_FLOATIS_DEF,
  parameter logic [2:0] OP_FMUL    = OP_FMUL_DEF,
  parameter logic [2:0] OP_FADD    = OP_FADD_DEF,
  parameter logic [2:0] OP_FIXSI   = OP_FIXSI_DEF,
  parameter int         TIMEOUT    = 64
) (
  input  logic                                   s2_clk,
  input  logic                                   s2_reset,
  input  logic                                   sample_ready,
  input  logic [32*N_CH-1:0]                     sample_aud,
  input  logic                                   coef_we,
  input  logic [$clog2((N_CH > 1) ? N_CH : 2)-1:0] coef_addr,
  input  logic [31:0]                            coef_wdata,
  output logic                                   fp_clk_en,
  output logic                                   fp_start,
  output logic [2:0]                             fp_n,
  output logic [31:0]                            fp_dataa,
  output logic [31:0]                            fp_datab,
  input  logic                                   fp_done,
  input  logic [31:0]                            fp_result,
  output logic [31:0]                            output_sample,
  output logic                                   out_valid,
  output logic                                   busy,
  output logic                                   overrun,
  output logic                                   fp_timeout
);

  localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  logic [AW-1:0] r_ch;
  logic [31:0]   r_frame [N_CH];
  logic [31:0]   r_acc;
  logic [WW-1:0] r_wait;
  logic          r_fp_start;
  logic [2:0]    r_fp_n;
  logic [31:0]   r_dataa;
  logic [31:0]   r_datab;
  logic [31:0]   r_out;
  logic          r_ov;
  logic          r_busy;
  logic          r_overrun;
  logic          r_timeout;

  logic [31:0]   w_coef;
  logic [31:0]   w_wt;
  logic [AW-1:0] w_ch_nx;
  logic          w_last;
  logic          w_in_wait;
  state_t        w_adv_state;
  logic [2:0]    w_adv_n;
  logic [31:0]   w_adv_a;

  beam_coef_regs #(
    .N_CH (N_CH),
    .AW   (AW)
  ) u_coef (
    .i_clk   (s2_clk),
    .i_rst   (s2_reset),
    .i_we    (coef_we),
    .i_waddr (coef_addr),
    .i_wdata (coef_wdata),
    .i_raddr (r_ch),
    .o_rdata (w_coef)
  );

  // A weight written in the cycle the multiply operands are loaded must already apply.
  assign w_wt      = (coef_we && (coef_addr == r_ch)) ? coef_wdata : w_coef;
  assign w_ch_nx   = r_ch + AW'(1);
  assign w_last    = (int'(r_ch) == N_CH - 1);
  assign w_in_wait = (r_state == CVT_WAIT) || (r_state == MUL_WAIT) ||
                     (r_state == ADD_WAIT) || (r_state == FIX_WAIT);

  // Once the new accumulator is in fp_result, either convert the next channel or finish.
  always_comb begin
    w_adv_state = CVT_ISSUE;
    w_adv_n     = OP_FLOATIS;
    w_adv_a     = r_frame[w_ch_nx];
    if (w_last) begin
      w_adv_state = FIX_ISSUE;
      w_adv_n     = OP_FIXSI;
      w_adv_a     = fp_result;
    end
  end

  // Frame buffer is pure data: loaded on frame accept, no reset.
  always_ff @(posedge s2_clk) begin
    if ((r_state == IDLE) && sample_ready && !s2_reset) begin
      for (int i = 0; i < N_CH; i++) r_frame[i] <= sample_aud[32*i +: 32];
    end
  end

  always_ff @(posedge s2_clk) begin
    if (s2_reset) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_acc      <= '0;
      r_wait     <= '0;
      r_fp_start <= 1'b0;
      r_fp_n     <= '0;
      r_dataa    <= '0;
      r_datab    <= '0;
      r_out      <= '0;
      r_ov       <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_fp_start <= 1'b0;
      r_ov       <= 1'b0;
      if (sample_ready && (r_state != IDLE)) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (sample_ready) begin
            r_ch       <= '0;
            r_busy     <= 1'b1;
            r_state    <= CVT_ISSUE;
            r_fp_start <= 1'b1;
            r_fp_n     <= OP_FLOATIS;
            r_dataa    <= sample_aud[31:0];
            r_datab    <= '0;
          end
        end
        CVT_ISSUE: begin r_wait <= '0; r_state <= CVT_WAIT; end
        MUL_ISSUE: begin r_wait <= '0; r_state <= MUL_WAIT; end
        ADD_ISSUE: begin r_wait <= '0; r_state <= ADD_WAIT; end
        FIX_ISSUE: begin r_wait <= '0; r_state <= FIX_WAIT; end
        CVT_WAIT: begin
          if (fp_done) begin
            r_state    <= MUL_ISSUE;
            r_fp_start <= 1'b1;
            r_fp_n     <= OP_FMUL;
            r_dataa    <= fp_result;
            r_datab    <= w_wt;
          end
        end
        MUL_WAIT: begin
          if (fp_done) begin
            r_fp_start <= 1'b1;
            if (r_ch == '0) begin
              // First product seeds the accumulator; no add needed.
              r_acc   <= fp_result;
              r_state <= w_adv_state;
              r_fp_n  <= w_adv_n;
              r_dataa <= w_adv_a;
              r_datab <= '0;
              if (!w_last) r_ch <= w_ch_nx;
            end else begin
              r_state <= ADD_ISSUE;
              r_fp_n  <= OP_FADD;
              r_dataa <= r_acc;
              r_datab <= fp_result;
            end
          end
        end
        ADD_WAIT: begin
          if (fp_done) begin
            r_acc      <= fp_result;
            r_fp_start <= 1'b1;
            r_state    <= w_adv_state;
            r_fp_n     <= w_adv_n;
            r_dataa    <= w_adv_a;
            r_datab    <= '0;
            if (!w_last) r_ch <= w_ch_nx;
          end
        end
        FIX_WAIT: begin
          if (fp_done) begin
            r_out   <= fp_result;
            r_ov    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // A stuck core abandons the frame; output_sample keeps its last good value.
      if (w_in_wait && !fp_done) begin
        if (r_wait == WW'(TIMEOUT - 1)) begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_timeout <= 1'b1;
        end else begin
          r_wait <= r_wait + WW'(1);
        end
      end
    end
  end

  assign fp_clk_en     = 1'b1;
  assign fp_start      = r_fp_start;
  assign fp_n          = r_fp_n;
  assign fp_dataa      = r_dataa;
  assign fp_datab      = r_datab;
  assign output_sample = r_out;
  assign out_valid     = r_ov;
  assign busy          = r_busy;
  assign overrun       = r_overrun;
  assign fp_timeout    = r_timeout;

endmodule
